// File: rtl/lsq_dmem_ctrl.sv
// Memory-side end of the LSQ: issues loads/stores one at a time on the memory bus, tracks
// outstanding loads in MSHRs and returns load data on the CDB. Option macro: DMEM_PERF_CNT_EN.
module lsq_dmem_ctrl #(
  parameter int PRF_SIZE  = 64,
  parameter int ROB_SIZE  = 32,
  parameter int MSHR_NUM  = 4,
  parameter int MEM_TAG_W = 4,
  localparam int PRF_W  = $clog2(PRF_SIZE),
  localparam int ROB_W  = $clog2(ROB_SIZE),
  localparam int MSHR_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1,
  localparam int CNT_W  = $clog2(MSHR_NUM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lsq_ld_req_valid_i,
  input  logic [63:0]          lsq_ld_req_addr_i,
  input  logic [PRF_W-1:0]     lsq_ld_req_dest_tag_i,
  input  logic [ROB_W-1:0]     lsq_ld_req_rob_idx_i,
  output logic                 lsq_ld_req_ready_o,
  input  logic                 lsq_st_req_valid_i,
  input  logic [63:0]          lsq_st_req_addr_i,
  input  logic [63:0]          lsq_st_req_data_i,
  output logic                 lsq_st_req_ready_o,
  input  logic                 thread_mispredict_i,
  output logic [1:0]           proc2mem_command_o,
  output logic [63:0]          proc2mem_addr_o,
  output logic [63:0]          proc2mem_data_o,
  input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
  input  logic [63:0]          mem2proc_data_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
  output logic [PRF_W-1:0]     lsq_CDB_dest_tag_o,
  output logic [63:0]          lsq_CDB_result_out_o,
  output logic                 lsq_CDB_result_is_valid_o,
  output logic [ROB_W-1:0]     lsq_CDB_rob_idx_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ld_issued_o,
  output logic [31:0]          perf_st_issued_o,
  output logic [31:0]          perf_squash_drop_o,
  output logic [31:0]          perf_stall_cyc_o
`endif
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e             state_q, state_d;
  logic               req_st_q, req_st_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [63:0]        req_data_q, req_data_d;
  logic [PRF_W-1:0]   req_dest_q, req_dest_d;
  logic [ROB_W-1:0]   req_rob_q, req_rob_d;
  logic               alloc;

  logic [MSHR_NUM-1:0]  mshr_valid_q, mshr_valid_d;
  logic [MSHR_NUM-1:0]  mshr_sq_q, mshr_sq_d;
  logic [MEM_TAG_W-1:0] mshr_tag_q  [MSHR_NUM];
  logic [PRF_W-1:0]     mshr_dest_q [MSHR_NUM];
  logic [ROB_W-1:0]     mshr_rob_q  [MSHR_NUM];
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
  logic [MSHR_NUM-1:0]  hit_vec;
  logic                 hit_any;
  logic [MSHR_W-1:0]    hit_idx, free_idx;
  logic                 cdb_valid_d;

  // Byte offset within the doubleword never reaches the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lsq_ld_req_addr_i[2:0], lsq_st_req_addr_i[2:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      req_st_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_dest_q <= '0;
      req_rob_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_st_q   <= req_st_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_dest_q <= req_dest_d;
      req_rob_q  <= req_rob_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    req_st_d           = req_st_q;
    req_addr_d         = req_addr_q;
    req_data_d         = req_data_q;
    req_dest_d         = req_dest_q;
    req_rob_d          = req_rob_q;
    alloc              = 1'b0;
    lsq_ld_req_ready_o = 1'b0;
    lsq_st_req_ready_o = 1'b0;
    proc2mem_command_o = CMD_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    case (state_q)
      S_IDLE: begin
        // Readies are gated by reset so every output reads 0 while reset is held.
        lsq_st_req_ready_o = rst_ni;
        lsq_ld_req_ready_o = rst_ni && !lsq_st_req_valid_i && (free_cnt_q != '0) &&
                             !thread_mispredict_i;
        if (lsq_st_req_valid_i && lsq_st_req_ready_o) begin
          state_d    = S_REQ;
          req_st_d   = 1'b1;
          req_addr_d = {lsq_st_req_addr_i[63:3], 3'b000};
          req_data_d = lsq_st_req_data_i;
          req_dest_d = '0;
          req_rob_d  = '0;
        end else if (lsq_ld_req_valid_i && lsq_ld_req_ready_o) begin
          state_d    = S_REQ;
          req_st_d   = 1'b0;
          req_addr_d = {lsq_ld_req_addr_i[63:3], 3'b000};
          req_data_d = '0;
          req_dest_d = lsq_ld_req_dest_tag_i;
          req_rob_d  = lsq_ld_req_rob_idx_i;
        end
      end
      S_REQ: begin
        if (!req_st_q && thread_mispredict_i) begin
          state_d = S_IDLE;
        end else begin
          proc2mem_command_o = req_st_q ? CMD_STORE : CMD_LOAD;
          proc2mem_addr_o    = req_addr_q;
          proc2mem_data_o    = req_st_q ? req_data_q : '0;
          if (mem2proc_response_i != '0) begin
            state_d = S_IDLE;
            alloc   = !req_st_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < MSHR_NUM; gi++) begin : g_hit
    assign hit_vec[gi] = mshr_valid_q[gi] && (mem2proc_tag_i != '0) &&
                         (mshr_tag_q[gi] == mem2proc_tag_i);
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    // Descending scan leaves the lowest-numbered match/free slot selected.
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = MSHR_W'(i);
      end
      if (!mshr_valid_q[i]) free_idx = MSHR_W'(i);
    end
    mshr_valid_d = mshr_valid_q & ~hit_vec;
    mshr_sq_d    = thread_mispredict_i ? (mshr_sq_q | mshr_valid_q) : mshr_sq_q;
    if (alloc) begin
      mshr_valid_d[free_idx] = 1'b1;
      mshr_sq_d[free_idx]    = 1'b0;
    end
    free_cnt_d = '0;
    for (int i = 0; i < MSHR_NUM; i++) free_cnt_d = free_cnt_d + CNT_W'(!mshr_valid_d[i]);
    cdb_valid_d = hit_any && !mshr_sq_q[hit_idx] && !thread_mispredict_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mshr_valid_q              <= '0;
      mshr_sq_q                 <= '0;
      free_cnt_q                <= CNT_W'(MSHR_NUM);
      lsq_CDB_result_is_valid_o <= 1'b0;
      lsq_CDB_dest_tag_o        <= '0;
      lsq_CDB_result_out_o      <= '0;
      lsq_CDB_rob_idx_o         <= '0;
      for (int i = 0; i < MSHR_NUM; i++) begin
        mshr_tag_q[i]  <= '0;
        mshr_dest_q[i] <= '0;
        mshr_rob_q[i]  <= '0;
      end
    end else begin
      mshr_valid_q              <= mshr_valid_d;
      mshr_sq_q                 <= mshr_sq_d;
      free_cnt_q                <= free_cnt_d;
      lsq_CDB_result_is_valid_o <= cdb_valid_d;
      lsq_CDB_dest_tag_o        <= cdb_valid_d ? mshr_dest_q[hit_idx] : '0;
      lsq_CDB_result_out_o      <= cdb_valid_d ? mem2proc_data_i : '0;
      lsq_CDB_rob_idx_o         <= cdb_valid_d ? mshr_rob_q[hit_idx] : '0;
      if (alloc) begin
        mshr_tag_q[free_idx]  <= mem2proc_response_i;
        mshr_dest_q[free_idx] <= req_dest_q;
        mshr_rob_q[free_idx]  <= req_rob_q;
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_drop_q, perf_stall_q;
  logic        resp_seen;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign resp_seen = (mem2proc_response_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ld_q    <= '0;
      perf_st_q    <= '0;
      perf_drop_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ld_q    <= sat_inc(perf_ld_q, (proc2mem_command_o == CMD_LOAD) && resp_seen);
      perf_st_q    <= sat_inc(perf_st_q, (proc2mem_command_o == CMD_STORE) && resp_seen);
      perf_drop_q  <= sat_inc(perf_drop_q, hit_any && !cdb_valid_d);
      perf_stall_q <= sat_inc(perf_stall_q, (state_q == S_REQ) && !resp_seen);
    end
  end

  assign perf_ld_issued_o   = perf_ld_q;
  assign perf_st_issued_o   = perf_st_q;
  assign perf_squash_drop_o = perf_drop_q;
  assign perf_stall_cyc_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsq_dmem_ctrl.sv
// Bench for lsq_dmem_ctrl: directed vector table, hand-written corner sequences, then
// random traffic against a queue-based model of the outstanding loads.
module tb_lsq_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ldv, stv, misp, ld_ready, st_ready, cv;
  logic [63:0] ld_addr, st_addr, st_data, paddr, pdata, mdata, cdata;
  logic [5:0]  ld_dest, cdest;
  logic [4:0]  ld_rob, crob;
  logic [3:0]  resp, mtag;
  logic [1:0]  cmd;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] p_ld, p_st, p_drop, p_stall;
`endif

  always #5 clk = ~clk;

  lsq_dmem_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsq_ld_req_valid_i(ldv), .lsq_ld_req_addr_i(ld_addr), .lsq_ld_req_dest_tag_i(ld_dest),
    .lsq_ld_req_rob_idx_i(ld_rob), .lsq_ld_req_ready_o(ld_ready),
    .lsq_st_req_valid_i(stv), .lsq_st_req_addr_i(st_addr), .lsq_st_req_data_i(st_data),
    .lsq_st_req_ready_o(st_ready), .thread_mispredict_i(misp),
    .proc2mem_command_o(cmd), .proc2mem_addr_o(paddr), .proc2mem_data_o(pdata),
    .mem2proc_response_i(resp), .mem2proc_data_i(mdata), .mem2proc_tag_i(mtag),
    .lsq_CDB_dest_tag_o(cdest), .lsq_CDB_result_out_o(cdata),
    .lsq_CDB_result_is_valid_o(cv), .lsq_CDB_rob_idx_o(crob)
`ifdef DMEM_PERF_CNT_EN
    , .perf_ld_issued_o(p_ld), .perf_st_issued_o(p_st),
    .perf_squash_drop_o(p_drop), .perf_stall_cyc_o(p_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ldv = 0; stv = 0; misp = 0; resp = 0; mtag = 0; mdata = 0;
    ld_addr = 0; ld_dest = 0; ld_rob = 0; st_addr = 0; st_data = 0;
  endtask

  typedef struct {
    logic stv, ldv, misp;
    logic [3:0] resp, mtag;
    logic [63:0] mdata, ld_addr;
    logic [5:0] ld_dest;
    logic [4:0] ld_rob;
    logic [63:0] st_addr, st_data;
    logic e_ldr, e_str;
    logic [1:0] e_cmd;
    logic [63:0] e_paddr, e_pdata;
    logic e_cv;
    logic [5:0] e_cdest;
    logic [63:0] e_cdata;
    logic [4:0] e_crob;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic s, input logic l, input logic [3:0] rp, input logic [3:0] tg,
                     input logic [63:0] md, input logic [63:0] la, input logic [5:0] ld,
                     input logic [4:0] lr, input logic [63:0] sa, input logic [63:0] sd,
                     input logic eld, input logic est, input logic [1:0] ec,
                     input logic [63:0] ea, input logic [63:0] ed, input logic ev,
                     input logic [5:0] edt, input logic [63:0] edd, input logic [4:0] er);
    vec_t v;
    v.stv = s; v.ldv = l; v.misp = 0; v.resp = rp; v.mtag = tg; v.mdata = md;
    v.ld_addr = la; v.ld_dest = ld; v.ld_rob = lr; v.st_addr = sa; v.st_data = sd;
    v.e_ldr = eld; v.e_str = est; v.e_cmd = ec; v.e_paddr = ea; v.e_pdata = ed;
    v.e_cv = ev; v.e_cdest = edt; v.e_cdata = edd; v.e_crob = er;
    tbl.push_back(v);
  endtask

  task automatic issue_load(input logic [63:0] a, input logic [5:0] d, input logic [4:0] r,
                            input logic [3:0] t);
    @(negedge clk); ldv = 1; ld_addr = a; ld_dest = d; ld_rob = r;
    #1 chk("issue ld_ready", 64'(ld_ready), 64'd1);
    @(negedge clk); ldv = 0; resp = t;
    #1 chk("issue cmd", 64'(cmd), 64'd1);
    @(negedge clk); resp = 0;
    $display("load addr 0x%0h dest %0d tag %0d issued", a, d, t);
  endtask

  task automatic return_tag(input logic [3:0] t, input logic [63:0] d, input logic ev,
                            input logic [5:0] edest);
    @(negedge clk); mtag = t; mdata = d;
    @(negedge clk); mtag = 0; mdata = 0;
    #1 chk("return cdb_valid", 64'(cv), 64'(ev));
    if (ev) begin
      chk("return cdb_dest", 64'(cdest), 64'(edest));
      chk("return cdb_data", cdata, d);
    end
    $display("tag %0d returned, cdb_valid %0b", t, cv);
  endtask

  // Reference model: outstanding loads as a queue, plus the single pending bus request.
  typedef struct { logic [3:0] tag; logic [5:0] dest; logic [4:0] rob; bit sq; } ld_t;
  ld_t outq[$];

  function automatic bit in_q(input logic [3:0] t);
    foreach (outq[i]) if (outq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] pick_tag(input logic [3:0] excl);
    logic [3:0] t;
    do t = 4'($urandom_range(1, 15)); while (in_q(t) || t == excl);
    return t;
  endfunction

  initial begin
    bit m_busy, m_st, e_ldr, e_str, e_cv, n_cv;
    logic [63:0] m_addr, m_data, e_paddr, e_pdata, e_cdata;
    logic [5:0] m_dest, e_cdest;
    logic [4:0] m_rob, e_crob;
    logic [1:0] e_cmd;
    int hi;

    idle_inputs();
    // cycle-by-cycle vectors: single load, store/load priority, stalled response
    add(0,1,0,0,0,            64'h1004,7,3,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,3,0,0,            64'h1004,7,3,0,0,         0,0,1,64'h1000,0,        0,0,0,0);
    add(0,0,0,0,0,            64'h1004,7,3,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,0,3,64'hDEAD,     64'h1004,7,3,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,0,0,0,            64'h1004,7,3,0,0,         1,1,0,0,0,               1,7,64'hDEAD,3);
    add(0,0,0,0,0,            64'h1004,7,3,0,0,         1,1,0,0,0,               0,0,0,0);
    add(1,1,0,0,0,            64'h3008,9,4,64'h2000,64'h55, 0,1,0,0,0,           0,0,0,0);
    add(0,1,2,0,0,            64'h3008,9,4,64'h2000,64'h55, 0,0,2,64'h2000,64'h55, 0,0,0,0);
    add(0,1,0,0,0,            64'h3008,9,4,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,0,0,0,            64'h3008,9,4,0,0,         0,0,1,64'h3008,0,        0,0,0,0);
    add(0,0,0,0,0,            64'h3008,9,4,0,0,         0,0,1,64'h3008,0,        0,0,0,0);
    add(0,0,0,0,0,            64'h3008,9,4,0,0,         0,0,1,64'h3008,0,        0,0,0,0);
    add(0,0,5,0,0,            64'h3008,9,4,0,0,         0,0,1,64'h3008,0,        0,0,0,0);
    add(0,0,0,0,0,            64'h3008,9,4,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,0,5,64'h1234,     64'h3008,9,4,0,0,         1,1,0,0,0,               0,0,0,0);
    add(0,0,0,0,0,            64'h3008,9,4,0,0,         1,1,0,0,0,               1,9,64'h1234,4);

    // reset state
    repeat (2) @(negedge clk);
    stv = 1; ldv = 1;
    #1;
    chk("rst ld_ready", 64'(ld_ready), 0); chk("rst st_ready", 64'(st_ready), 0);
    chk("rst cmd", 64'(cmd), 0); chk("rst addr", paddr, 0); chk("rst cdb_valid", 64'(cv), 0);
    idle_inputs();
    @(negedge clk); rst_n = 1;
    #1 chk("post-rst st_ready", 64'(st_ready), 1); chk("post-rst ld_ready", 64'(ld_ready), 1);

    foreach (tbl[k]) begin
      @(negedge clk);
      stv = tbl[k].stv; ldv = tbl[k].ldv; misp = tbl[k].misp; resp = tbl[k].resp;
      mtag = tbl[k].mtag; mdata = tbl[k].mdata; ld_addr = tbl[k].ld_addr;
      ld_dest = tbl[k].ld_dest; ld_rob = tbl[k].ld_rob;
      st_addr = tbl[k].st_addr; st_data = tbl[k].st_data;
      #1;
      chk($sformatf("v%0d ld_ready", k), 64'(ld_ready), 64'(tbl[k].e_ldr));
      chk($sformatf("v%0d st_ready", k), 64'(st_ready), 64'(tbl[k].e_str));
      chk($sformatf("v%0d cmd", k), 64'(cmd), 64'(tbl[k].e_cmd));
      chk($sformatf("v%0d addr", k), paddr, tbl[k].e_paddr);
      chk($sformatf("v%0d data", k), pdata, tbl[k].e_pdata);
      chk($sformatf("v%0d cdb_valid", k), 64'(cv), 64'(tbl[k].e_cv));
      if (tbl[k].e_cv) begin
        chk($sformatf("v%0d cdb_dest", k), 64'(cdest), 64'(tbl[k].e_cdest));
        chk($sformatf("v%0d cdb_data", k), cdata, tbl[k].e_cdata);
        chk($sformatf("v%0d cdb_rob", k), 64'(crob), 64'(tbl[k].e_crob));
      end
      $display("vector %0d: cmd %0d addr 0x%0h cdb_valid %0b", k, cmd, paddr, cv);
    end
    idle_inputs();

    // all MSHRs busy, one returns: ld_ready rises a cycle later
    for (int i = 0; i < 4; i++) issue_load(64'(32'h100 * (i + 1)), 6'(10 + i), 5'(i), 4'(i + 1));
    @(negedge clk); ldv = 1; mtag = 2; mdata = 64'hBEEF;
    #1 chk("full ld_ready", 64'(ld_ready), 0);
    @(negedge clk); ldv = 0; mtag = 0; mdata = 0;
    #1 chk("freed ld_ready", 64'(ld_ready), 1); chk("freed cdb_valid", 64'(cv), 1);
    chk("freed cdb_dest", 64'(cdest), 11); chk("freed cdb_data", cdata, 64'hBEEF);
    chk("freed cdb_rob", 64'(crob), 1);
    return_tag(1, 64'h11, 1, 10);
    return_tag(3, 64'h33, 1, 12);
    return_tag(4, 64'h44, 1, 13);

    // mispredict squashes two outstanding loads
    issue_load(64'h4000, 20, 6, 6);
    issue_load(64'h4008, 21, 7, 7);
    @(negedge clk); misp = 1; ldv = 1;
    #1 chk("misp ld_ready", 64'(ld_ready), 0);
    @(negedge clk); misp = 0; ldv = 0;
    return_tag(6, 64'h66, 0, 0);
    return_tag(7, 64'h77, 0, 0);
    for (int i = 0; i < 4; i++) issue_load(64'(32'h5000 + 8 * i), 6'(30 + i), 5'(8 + i), 4'(8 + i));
    return_tag(8, 64'h88, 1, 30);

    // reset with three loads outstanding; their tags later match nothing
    @(negedge clk); rst_n = 0; stv = 1;
    #1 chk("midrst st_ready", 64'(st_ready), 0); chk("midrst cmd", 64'(cmd), 0);
    chk("midrst cdb_valid", 64'(cv), 0);
    @(negedge clk); stv = 0; rst_n = 1;
    return_tag(9, 64'h99, 0, 0);
    return_tag(10, 64'hAA, 0, 0);
    return_tag(11, 64'hBB, 0, 0);
    #1 chk("after-rst ld_ready", 64'(ld_ready), 1); chk("after-rst cmd", 64'(cmd), 0);
    chk("after-rst cdb_data", cdata, 0);

    // random traffic vs. model
    m_busy = 0; m_st = 0; m_addr = 0; m_data = 0; m_dest = 0; m_rob = 0;
    e_cv = 0; e_cdest = 0; e_cdata = 0; e_crob = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stv = ($urandom_range(0, 3) == 0); ldv = 1'($urandom_range(0, 1));
      misp = ($urandom_range(0, 19) == 0);
      ld_addr = {$urandom, $urandom}; st_addr = {$urandom, $urandom};
      st_data = {$urandom, $urandom}; mdata = {$urandom, $urandom};
      ld_dest = 6'($urandom_range(0, 63)); ld_rob = 5'($urandom_range(0, 31));
      if (!m_busy) begin
        e_str = 1; e_ldr = !stv && outq.size() < 4 && !misp;
        e_cmd = 0; e_paddr = 0; e_pdata = 0;
      end else begin
        e_str = 0; e_ldr = 0;
        if (!m_st && misp) begin
          e_cmd = 0; e_paddr = 0; e_pdata = 0;
        end else begin
          e_cmd = m_st ? 2'd2 : 2'd1; e_paddr = {m_addr[63:3], 3'b000};
          e_pdata = m_st ? m_data : 64'd0;
        end
      end
      mtag = 0;
      if (outq.size() > 0 && $urandom_range(0, 2) == 0)
        mtag = outq[$urandom_range(0, outq.size() - 1)].tag;
      else if ($urandom_range(0, 9) == 0) mtag = pick_tag(0);
      resp = 0;
      if (e_cmd != 0 && $urandom_range(0, 1) == 1) resp = pick_tag(mtag);
      #1;
      chk("rnd ld_ready", 64'(ld_ready), 64'(e_ldr));
      chk("rnd st_ready", 64'(st_ready), 64'(e_str));
      chk("rnd cmd", 64'(cmd), 64'(e_cmd));
      chk("rnd addr", paddr, e_paddr);
      chk("rnd data", pdata, e_pdata);
      chk("rnd cdb_valid", 64'(cv), 64'(e_cv));
      if (e_cv) begin
        chk("rnd cdb_dest", 64'(cdest), 64'(e_cdest));
        chk("rnd cdb_data", cdata, e_cdata);
        chk("rnd cdb_rob", 64'(crob), 64'(e_crob));
      end
      if (resp != 0) $display("rnd cycle %0d: %s addr 0x%0h accepted with tag %0d",
                              cyc, m_st ? "store" : "load", e_paddr, resp);
      hi = -1;
      foreach (outq[i]) if (mtag != 0 && outq[i].tag == mtag) hi = i;
      n_cv = 0;
      if (hi >= 0) begin
        n_cv = !outq[hi].sq && !misp;
        e_cdest = outq[hi].dest; e_crob = outq[hi].rob; e_cdata = mdata;
        outq.delete(hi);
      end
      e_cv = n_cv;
      if (misp) foreach (outq[i]) outq[i].sq = 1;
      if (!m_busy) begin
        if (stv) begin
          m_busy = 1; m_st = 1; m_addr = st_addr; m_data = st_data;
        end else if (ldv && e_ldr) begin
          m_busy = 1; m_st = 0; m_addr = ld_addr; m_dest = ld_dest; m_rob = ld_rob;
        end
      end else if (!m_st && misp) begin
        m_busy = 0;
      end else if (resp != 0) begin
        m_busy = 0;
        if (!m_st) outq.push_back('{tag: resp, dest: m_dest, rob: m_rob, sq: 1'b0});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
